// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: synchronises sclk/cs_n/mosi into the system clock domain,
// receives 16-bit MSB-first words and shifts out a preloaded word on MISO.
module spi_slave_if #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_sysclk,
  input  logic              i_sysrst_n,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  input  logic              i_tx_ld,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_tx_empty,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_frame_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state, state_nxt;

  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [2:0] mosi_sync;
  logic [1:0] sync_vld;
  logic       armed;

  logic              sclk_rise, sclk_fall;
  logic              cs_fall, cs_rise;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] tx_hold;
  logic              reload;

  logic start, stop, load_tx, shift_tx, shift_rx, abort;

  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], i_sclk};
      cs_sync   <= {cs_sync[1:0], i_cs_n};
      mosi_sync <= {mosi_sync[1:0], i_mosi};
    end
  end

  // The reset values of cs_sync are not real pin samples, so a CS start only
  // counts once a genuinely synchronised high level has been observed.
  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst_n) begin
      sync_vld <= '0;
      armed    <= 1'b0;
    end else begin
      sync_vld <= {sync_vld[0], 1'b1};
      armed    <= armed | (sync_vld[1] & cs_sync[1]);
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall   = armed & ~cs_sync[1] & cs_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];

  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stop      = 1'b0;
    load_tx   = 1'b0;
    shift_tx  = 1'b0;
    shift_rx  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = ACTIVE;
          start     = 1'b1;
          load_tx   = 1'b1;
        end
      end
      ACTIVE: begin
        // CS end wins over any sclk edge seen in the same cycle.
        if (cs_rise) begin
          state_nxt = IDLE;
          stop      = 1'b1;
          abort     = (bit_cnt != '0);
        end else begin
          shift_rx = sclk_rise;
          if (sclk_fall) begin
            load_tx  = reload;
            shift_tx = ~reload;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst_n) begin
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      tx_hold     <= '0;
      reload      <= 1'b0;
      o_tx_empty  <= 1'b1;
      o_rx_data   <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;

      if (load_tx) begin
        tx_sr <= o_tx_empty ? '0 : tx_hold;
      end else if (shift_tx) begin
        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
      end

      // A load in the transfer cycle refills the holding register after the
      // shift register has taken the previous value.
      if (i_tx_ld) begin
        tx_hold    <= i_tx_data;
        o_tx_empty <= 1'b0;
      end else if (load_tx) begin
        o_tx_empty <= 1'b1;
      end

      if (start) begin
        bit_cnt <= '0;
      end

      if (load_tx || stop) begin
        reload <= 1'b0;
      end

      if (shift_rx) begin
        rx_sr <= {rx_sr[DATA_W-2:0], mosi_sync[2]};
        if (bit_cnt == LAST) begin
          bit_cnt    <= '0;
          o_rx_data  <= {rx_sr[DATA_W-2:0], mosi_sync[2]};
          o_rx_valid <= 1'b1;
          reload     <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (stop) begin
        o_frame_err <= abort;
      end
    end
  end

  assign o_miso_oe = ~cs_sync[2];
  assign o_miso    = o_miso_oe & tx_sr[DATA_W-1];

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: acts as a mode-0 SPI master and checks
// received words, MISO words, strobes and reset behaviour.
module tb_spi_slave_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, cs_n, mosi;
  logic        miso, miso_oe;
  logic        tx_ld;
  logic [15:0] tx_data;
  logic        tx_empty;
  logic [15:0] rx_data;
  logic        rx_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int ecnt   = 0;
  int v0, e0;
  logic [15:0] m;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(16)) dut (
    .i_sysclk   (clk),
    .i_sysrst_n (rst_n),
    .i_sclk     (sclk),
    .i_cs_n     (cs_n),
    .i_mosi     (mosi),
    .o_miso     (miso),
    .o_miso_oe  (miso_oe),
    .i_tx_ld    (tx_ld),
    .i_tx_data  (tx_data),
    .o_tx_empty (tx_empty),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .o_frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (rx_valid) vcnt++;
    if (frame_err) ecnt++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] d);
    tx_data = d;
    tx_ld   = 1'b1;
    cyc(1);
    tx_ld   = 1'b0;
  endtask

  task automatic shift(input logic [15:0] w, input int n, output logic [15:0] mo);
    mo = '0;
    for (int i = 0; i < n; i++) begin
      mosi = w[15-i];
      cyc(6);
      mo   = {mo[14:0], miso};
      sclk = 1'b1;
      cyc(6);
      sclk = 1'b0;
    end
    cyc(4);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    cyc(8);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    cyc(8);
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_ld = 1'b0; tx_data = '0;
    cyc(3);
    check("rst_miso", {15'd0, miso}, 16'd0);
    check("rst_oe", {15'd0, miso_oe}, 16'd0);
    check("rst_rx_data", rx_data, 16'h0000);
    check("rst_rx_valid", {15'd0, rx_valid}, 16'd0);
    check("rst_frame_err", {15'd0, frame_err}, 16'd0);
    check("rst_tx_empty", {15'd0, tx_empty}, 16'd1);
    rst_n = 1'b1;
    cyc(10);

    // Single read, with CS-fall latency and 16th-rise latency checks
    load(16'hA5C3);
    check("ld_empty", {15'd0, tx_empty}, 16'd0);
    v0 = vcnt;
    cs_n = 1'b0;
    cyc(2);
    check("cs_lat2_oe", {15'd0, miso_oe}, 16'd0);
    cyc(1);
    check("cs_lat3_oe", {15'd0, miso_oe}, 16'd1);
    check("cs_lat3_miso", {15'd0, miso}, 16'd1);
    check("single_empty", {15'd0, tx_empty}, 16'd1);
    cyc(5);
    shift(16'h1234, 15, m);
    mosi = 1'b0;
    cyc(6);
    m = {m[14:0], miso};
    sclk = 1'b1;
    cyc(2);
    check("rv_lat2", {15'd0, rx_valid}, 16'd0);
    cyc(1);
    check("rv_lat3", {15'd0, rx_valid}, 16'd1);
    check("single_rx_at_pulse", rx_data, 16'h1234);
    cyc(1);
    check("rv_one_cycle", {15'd0, rx_valid}, 16'd0);
    cyc(2);
    sclk = 1'b0;
    cyc(10);
    cs_high();
    check("single_miso", m, 16'hA5C3);
    check("single_rx", rx_data, 16'h1234);
    check("single_vcnt", 16'(vcnt - v0), 16'd1);
    check("idle_oe", {15'd0, miso_oe}, 16'd0);

    // Back-to-back frames under one CS
    load(16'h00FF);
    v0 = vcnt;
    cs_low();
    load(16'hFF00);
    shift(16'hBEEF, 16, m);
    check("b2b_miso0", m, 16'h00FF);
    check("b2b_rx0", rx_data, 16'hBEEF);
    shift(16'hCAFE, 16, m);
    check("b2b_miso1", m, 16'hFF00);
    check("b2b_rx1", rx_data, 16'hCAFE);
    cs_high();
    check("b2b_vcnt", 16'(vcnt - v0), 16'd2);

    // Empty TX
    cs_low();
    shift(16'h0F0F, 16, m);
    cs_high();
    check("empty_miso", m, 16'h0000);
    check("empty_flag", {15'd0, tx_empty}, 16'd1);
    check("empty_rx", rx_data, 16'h0F0F);

    // Aborted frame after a good one
    cs_low();
    shift(16'h5555, 16, m);
    cs_high();
    check("abort_pre_rx", rx_data, 16'h5555);
    v0 = vcnt; e0 = ecnt;
    cs_low();
    shift(16'hFFFF, 9, m);
    cs_high();
    check("abort_err", 16'(ecnt - e0), 16'd1);
    check("abort_vcnt", 16'(vcnt - v0), 16'd0);
    check("abort_rx", rx_data, 16'h5555);

    // Reset during bit 7, with CS still low at reset release
    e0 = ecnt;
    cs_low();
    load(16'h7777);
    shift(16'hF0F0, 7, m);
    rst_n = 1'b0;
    cyc(1);
    check("mrst_miso", {15'd0, miso}, 16'd0);
    check("mrst_oe", {15'd0, miso_oe}, 16'd0);
    check("mrst_rx", rx_data, 16'h0000);
    check("mrst_empty", {15'd0, tx_empty}, 16'd1);
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    v0 = vcnt;
    shift(16'hFFFF, 16, m);
    check("cslow_rel_vcnt", 16'(vcnt - v0), 16'd0);
    cs_high();
    check("mrst_err", 16'(ecnt - e0), 16'd0);
    check("cslow_rel_rx", rx_data, 16'h0000);
    cs_low();
    shift(16'h8001, 16, m);
    cs_high();
    check("post_rst_rx", rx_data, 16'h8001);
    check("post_rst_vcnt", 16'(vcnt - v0), 16'd1);

    // Load colliding with CS-start transfer
    load(16'h2222);
    cs_n = 1'b0;
    cyc(2);
    tx_data = 16'h1111;
    tx_ld   = 1'b1;
    cyc(1);
    tx_ld   = 1'b0;
    check("coll_empty", {15'd0, tx_empty}, 16'd0);
    cyc(5);
    shift(16'h0000, 16, m);
    check("coll_miso0", m, 16'h2222);
    shift(16'h0000, 16, m);
    check("coll_miso1", m, 16'h1111);
    check("coll_empty_end", {15'd0, tx_empty}, 16'd1);
    cs_high();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

Serial slave port for the 16-bit counter design. It receives an externally driven SPI-mode-0 clock (`sclk`), plus chip select and MOSI, and synchronises all three into the system clock domain. It shifts in 16-bit MSB-first words, presenting each on a parallel output with a one-cycle valid strobe. It simultaneously shifts out a preloaded 16-bit word on MISO, forming the far end of the prescaler-driven `sclk`/edge-strobe master link.

## Interface
- DATA_W, 16, frame length in bits; fixed at 16, not overridden
- i_sysclk  input  1  system clock; must be ≥ 8× the `sclk` frequency
- i_sysrst_n  input  1  synchronous, active-low reset
- i_sclk  input  1  external serial clock, asynchronous, idles low
- i_cs_n  input  1  external chip select, asynchronous, active low
- i_mosi  input  1  serial data in, asynchronous
- o_miso  output  1  serial data out, MSB first
- o_miso_oe  output  1  MISO output enable, high while the synchronised CS is low
- i_tx_ld  input  1  load `i_tx_data` into the TX holding register
- i_tx_data  input  16  next word to transmit
- o_tx_empty  output  1  TX holding register empty
- o_rx_data  output  16  last complete received word
- o_rx_valid  output  1  one-cycle pulse when `o_rx_data` updates
- o_frame_err  output  1  one-cycle pulse when CS rises mid-frame

## Operation
- **Synchronisers.** `i_sclk`, `i_cs_n` and `i_mosi` each pass through a 2-flop synchroniser, plus a third history flop for edge detect.
  - Rise strobe: synced `sclk` 0→1. Fall strobe: synced `sclk` 1→0.
  - CS start: synced `cs_n` 1→0. CS end: synced `cs_n` 0→1.
  - On reset, the synchroniser flops take the idle levels: `sclk` = 0, `cs_n` = 1, `mosi` = 0.
- **States.**
  - IDLE: wait for a CS start.
  - ACTIVE: shift bits; a CS end returns to IDLE.
  - Edges on `sclk` are ignored in IDLE.
- **CS start (IDLE→ACTIVE).**
  - Bit counter ← 0.
  - TX shift register ← holding register if `o_tx_empty` = 0, else 16'h0000.
  - `o_tx_empty` ← 1 when a transfer occurred.
- **Rise strobe in ACTIVE.**
  - RX shift register ← {rx_sr[14:0], mosi_sync}; bit counter +1.
  - On the 16th rise (counter 15→0 wrap): `o_rx_data` ← the full word, and `o_rx_valid` pulses in the same cycle the register updates. A reload flag is set.
- **Fall strobe in ACTIVE.**
  - Reload flag set: TX shift register ← holding register or 16'h0000, using the same rule and `o_tx_empty` update as CS start; flag cleared. This supports back-to-back frames under one CS.
  - Otherwise: TX shift register shifts left by one, filling with 0.
- **MISO.**
  - `o_miso` = tx_sr[15].
  - `o_miso_oe` = ~cs_sync.
  - `o_miso` is driven 0 while `o_miso_oe` = 0.
- **CS end (ACTIVE→IDLE).**
  - If bit counter ≠ 0, `o_frame_err` pulses and `o_rx_data` is unchanged; the partial word is discarded.
  - The reload flag is cleared.
- **Holding register.**
  - `i_tx_ld` = 1 writes `i_tx_data` and clears `o_tx_empty`.
  - `i_tx_ld` in the same cycle as a transfer: the shift register takes the old holding value, the holding register takes the new data, and `o_tx_empty` = 0.
  - `i_tx_ld` while already full overwrites the held value.
- **Simultaneous events.** CS end and a rise strobe in the same cycle: the CS end takes priority and the rise is ignored.
- **CS low at reset release.** No frame starts until `cs_n` has been seen high and then low.

## Timing
- **Reset values:**
  - `o_miso` 0, `o_miso_oe` 0, `o_rx_data` 16'h0000
  - `o_rx_valid` 0, `o_frame_err` 0, `o_tx_empty` 1
  - state IDLE, counter 0, both shift registers 0
- **Latency (pin edge to internal effect):** 3 `i_sysclk` cycles for any external pin edge.
  - A CS fall reaches `o_miso_oe`/`o_miso` 3 cycles later.
  - A 16th `sclk` rise reaches `o_rx_valid` 3 cycles later.
- **MISO change:** 3 cycles after an `sclk` fall. This is valid before the next rise because `i_sysclk` is ≥ 8× `sclk`.
- **Input setup:** MOSI must be stable ≥ 3 `i_sysclk` cycles before each `sclk` rise.
- **Reset mid-frame:** all outputs return to reset values in the next cycle; a partial word produces no `o_rx_valid` and no `o_frame_err`.

## Test plan
- **Single read.**
  - Reset, `i_tx_ld` with 16'hA5C3.
  - CS low, 16 `sclk` cycles with MOSI = 16'h1234.
  - Required: `o_rx_data` = 16'h1234 and one `o_rx_valid` pulse; MISO bits read 16'hA5C3; `o_tx_empty` = 1 after CS start.
- **Back-to-back frames.**
  - Load 16'h00FF, then 16'hFF00 after the first transfer.
  - 32 clocks under one CS, MOSI = 16'hBEEF, 16'hCAFE.
  - Required: two `o_rx_valid` pulses; MISO = 16'h00FF then 16'hFF00.
- **Empty TX.** No load, one frame → MISO = 16'h0000; `o_tx_empty` stays 1.
- **Aborted frame.**
  - Complete a full frame of 16'h5555, then a new frame raising CS after 9 bits.
  - Required: `o_frame_err` pulses once, no `o_rx_valid`, `o_rx_data` still 16'h5555.
- **Reset during bit 7.** Required: all outputs at reset values; a following full frame of 16'h8001 is received correctly.
- **Load/transfer collision.**
  - `i_tx_ld` with 16'h1111 in the exact cycle of a CS-start transfer of a held 16'h2222.
  - Required: MISO = 16'h2222; `o_tx_empty` = 0, holding 16'h1111.
